// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   state_t          fetch FSM state encoding (2 bits)
//   IF_NOP_INSTR     word delivered in place of a faulting fetch
//   IF_RESET_PC      reset PC, shared with the PC register
//   pc_plus4()       32-bit wrap-around PC increment
`timescale 1ns/1ps
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a req/ack memory handshake and an IF/ID
// output register. pc_advance enables the upstream PC register so the PC
// moves only when an entry is consumed or on a redirect.
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   pc                      current PC register value
//   pc_advance              PC register load enable for this edge
//   flush                   redirect; current fetch is discarded
//   id_stall                decode cannot accept the IF/ID entry
//   imem_req, imem_addr     memory request (address held until ack)
//   imem_ack, imem_rdata    memory response
//   if_valid, if_instr, if_pc, if_add4, if_exc   IF/ID register
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_ISSUE | latch pc; misaligned pc loads a fault entry, else request
// S_REQ   | request outstanding; wait for ack (drop it after a flush)
// S_HOLD  | IF/ID entry valid; wait for decode to accept it or a flush
`timescale 1ns/1ps
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc,
  output logic        pc_advance,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_add4,
  output logic        if_exc
);

  state_t      state, state_nxt;
  logic [31:0] req_addr;
  logic        drop;
  logic        misaligned;
  logic        load_fault, load_mem, clear_valid, set_drop, clr_drop;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_ISSUE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_fault  = 1'b0;
    load_mem    = 1'b0;
    clear_valid = 1'b0;
    set_drop    = 1'b0;
    clr_drop    = 1'b0;
    case (state)
      S_ISSUE: begin
        // A redirect here just re-latches the new pc next cycle.
        if (!flush) begin
          if (misaligned) begin
            load_fault = 1'b1;
            state_nxt  = S_HOLD;
          end else begin
            state_nxt  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (drop || flush) begin
            clr_drop  = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            load_mem  = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (flush) begin
          // The request cannot be withdrawn; remember to discard its ack.
          set_drop = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush || !id_stall) begin
          clear_valid = 1'b1;
          state_nxt   = S_ISSUE;
        end
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  assign pc_advance = !Reset && (flush || (state == S_HOLD && !id_stall));
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = req_addr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_exc   <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= RESET_PC;
      if_add4  <= pc_plus4(RESET_PC);
    end else begin
      if (state == S_ISSUE) req_addr <= pc;

      if (set_drop)      drop <= 1'b1;
      else if (clr_drop) drop <= 1'b0;

      if (load_fault) begin
        if_valid <= 1'b1;
        if_exc   <= 1'b1;
        if_instr <= NOP_INSTR;
        if_pc    <= pc;
        if_add4  <= pc_plus4(pc);
      end else if (load_mem) begin
        if_valid <= 1'b1;
        if_exc   <= 1'b0;
        if_instr <= imem_rdata;
        if_pc    <= req_addr;
        if_add4  <= pc_plus4(req_addr);
      end else if (clear_valid) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
